// File: rtl/gemm_stream_host.sv
// gemm_stream_host
// Host side of the GEMM engine's start/busy/done interface. A job arrives as a
// valid/ready word stream (alpha, beta, then A, B and C row-major). Once it is
// fully loaded the operands are held on the engine-facing outputs, a one-cycle
// start pulse is issued, and done is awaited with a timeout. The result matrix
// is captured and streamed out row-major with valid/ready/last.
//
// Ports:
//   iclk, irst          clock, synchronous active-high reset
//   iin_valid/oin_ready/iin_data        job input stream
//   oalpha, obeta, oa/ob/oc_matrix      operands to the engine
//   ostart, ibusy, idone, iresult_matrix engine control/status and result
//   oout_valid/iout_ready/oout_data/oout_last  result output stream
//   otimeout            one-cycle pulse when the engine does not finish
//   obusy               high whenever a job is in progress (not loading)
module gemm_stream_host #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned MATRIX_WIDTH   = 4,
    parameter int unsigned MATRIX_HEIGHT  = 4,
    parameter int unsigned MATRIX_K       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         iclk,
    input  logic                         irst,
    input  logic                         iin_valid,
    output logic                         oin_ready,
    input  logic [DATA_WIDTH-1:0]        iin_data,
    output logic [DATA_WIDTH-1:0]        oalpha,
    output logic [DATA_WIDTH-1:0]        obeta,
    output logic signed [DATA_WIDTH-1:0] oa_matrix [MATRIX_HEIGHT][MATRIX_K],
    output logic signed [DATA_WIDTH-1:0] ob_matrix [MATRIX_K][MATRIX_WIDTH],
    output logic signed [DATA_WIDTH-1:0] oc_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
    output logic                         ostart,
    input  logic                         ibusy,
    input  logic                         idone,
    input  logic [DATA_WIDTH-1:0]        iresult_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
    output logic                         oout_valid,
    input  logic                         iout_ready,
    output logic [DATA_WIDTH-1:0]        oout_data,
    output logic                         oout_last,
    output logic                         otimeout,
    output logic                         obusy
);

    localparam int unsigned H      = MATRIX_HEIGHT;
    localparam int unsigned W      = MATRIX_WIDTH;
    localparam int unsigned K      = MATRIX_K;
    localparam int unsigned N_IN   = 2 + H * K + K * W + H * W;
    localparam int unsigned N_OUT  = H * W;
    localparam int unsigned LW     = $clog2(N_IN);
    localparam int unsigned OW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned A_BASE = 2;
    localparam int unsigned B_BASE = A_BASE + H * K;
    localparam int unsigned C_BASE = B_BASE + K * W;

    typedef enum logic [2:0] {
        StLoad,
        StStart,
        StWait,
        StCapture,
        StDrain
    } state_t;

    state_t                      r_state;
    state_t                      w_state_d;
    logic [LW-1:0]               r_load_cnt;
    logic [OW-1:0]               r_out_cnt;
    logic [OW-1:0]               w_out_nxt;
    logic [TW-1:0]               r_tmo_cnt;
    logic                        r_out_valid;
    logic                        r_out_last;
    logic [DATA_WIDTH-1:0]       r_out_data;
    logic [DATA_WIDTH-1:0]       r_alpha;
    logic [DATA_WIDTH-1:0]       r_beta;
    logic signed [DATA_WIDTH-1:0] r_a [H][K];
    logic signed [DATA_WIDTH-1:0] r_b [K][W];
    logic signed [DATA_WIDTH-1:0] r_c [H][W];
    logic [DATA_WIDTH-1:0]       r_result [N_OUT];
    logic                        w_in_fire;
    logic                        w_out_fire;
    logic                        w_tmo_hit;
    logic                        w_unused_busy;

    // Engine busy is informational only.
    assign w_unused_busy = ibusy;

    assign w_in_fire  = iin_valid && oin_ready;
    assign w_out_fire = r_out_valid && iout_ready;
    assign w_out_nxt  = r_out_cnt + OW'(1);
    assign w_tmo_hit  = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign oalpha     = r_alpha;
    assign obeta      = r_beta;
    assign oa_matrix  = r_a;
    assign ob_matrix  = r_b;
    assign oc_matrix  = r_c;
    assign oout_valid = r_out_valid;
    assign oout_data  = r_out_data;
    assign oout_last  = r_out_last;

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        oin_ready = 1'b0;
        ostart    = 1'b0;
        otimeout  = 1'b0;
        obusy     = (r_state != StLoad);
        unique case (r_state)
            StLoad: begin
                // Held low while reset is asserted so no word is taken then.
                oin_ready = !irst;
                if (w_in_fire && (r_load_cnt == LW'(N_IN - 1))) begin
                    w_state_d = StStart;
                end
            end
            StStart: begin
                ostart    = 1'b1;
                w_state_d = StWait;
            end
            StWait: begin
                // done wins over timeout when both land in the same cycle
                if (idone) begin
                    w_state_d = StCapture;
                end else if (w_tmo_hit) begin
                    otimeout  = 1'b1;
                    w_state_d = StLoad;
                end
            end
            StCapture: begin
                w_state_d = StDrain;
            end
            StDrain: begin
                if (w_out_fire && r_out_last) begin
                    w_state_d = StLoad;
                end
            end
            default: begin
                w_state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_load_cnt  <= '0;
            r_out_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_in_fire) begin
                r_load_cnt <= (r_load_cnt == LW'(N_IN - 1)) ? '0 : r_load_cnt + LW'(1);
            end
            // Cleared on either exit so every job gets the full timeout window.
            if (r_state == StWait) begin
                if (idone || w_tmo_hit) begin
                    r_tmo_cnt <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + TW'(1);
                end
            end
            if (r_state == StCapture) begin
                // First word comes straight from the engine; the buffer fills
                // on the same edge and supplies the rest.
                r_out_cnt   <= '0;
                r_out_data  <= iresult_matrix[0][0];
                r_out_valid <= 1'b1;
                r_out_last  <= (N_OUT == 1);
            end else if (w_out_fire) begin
                if (r_out_last) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_out_cnt   <= '0;
                end else begin
                    r_out_cnt  <= w_out_nxt;
                    r_out_data <= r_result[w_out_nxt];
                    r_out_last <= (w_out_nxt == OW'(N_OUT - 1));
                end
            end
        end
    end

    // Operand and result buffers are deliberately not reset.
    always_ff @(posedge iclk) begin
        if (w_in_fire) begin
            if (r_load_cnt == LW'(0)) r_alpha <= iin_data;
            if (r_load_cnt == LW'(1)) r_beta <= iin_data;
            for (int i = 0; i < int'(H); i++) begin
                for (int j = 0; j < int'(K); j++) begin
                    if (r_load_cnt == LW'(A_BASE + i * K + j)) r_a[i][j] <= iin_data;
                end
            end
            for (int i = 0; i < int'(K); i++) begin
                for (int j = 0; j < int'(W); j++) begin
                    if (r_load_cnt == LW'(B_BASE + i * W + j)) r_b[i][j] <= iin_data;
                end
            end
            for (int i = 0; i < int'(H); i++) begin
                for (int j = 0; j < int'(W); j++) begin
                    if (r_load_cnt == LW'(C_BASE + i * W + j)) r_c[i][j] <= iin_data;
                end
            end
        end
        if (r_state == StCapture) begin
            for (int i = 0; i < int'(H); i++) begin
                for (int j = 0; j < int'(W); j++) begin
                    r_result[i * W + j] <= iresult_matrix[i][j];
                end
            end
        end
    end

endmodule
